// File: rtl/sys_mem_resp_if.sv
// Valid/ready system memory bus, shared by initiators and memory responders.
// Signal names keep the i_/o_ direction prefixes as seen from the responder.
interface sys_mem_resp_if;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [3:0]  i_wstrb;
    logic [31:0] o_rdata;
    logic        o_err;

    modport master (
        output i_valid, i_addr, i_wdata, i_wstrb,
        input  o_ready, o_rdata, o_err
    );

    modport slave (
        input  i_valid, i_addr, i_wdata, i_wstrb,
        output o_ready, o_rdata, o_err
    );
endinterface

// File: rtl/sys_mem_resp.sv
// On-chip RAM responder for the system memory bus: programmable latency,
// byte-strobe writes, out-of-range flagging with a fixed error word.
module sys_mem_resp #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic         clk,
    input  logic         rst,
    sys_mem_resp_if.slave bus
);
    localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic                  access;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic [3:0]            acc_wstrb;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic                  acc_oor;
    logic [31:0]           mem_rd;
    logic [31:0]           merged;

    // With LATENCY=1 the access happens on the accept edge, so it must use
    // the live bus request rather than the (not yet loaded) latched copy.
    always_comb begin
        acc_addr  = (state_q == IDLE) ? bus.i_addr  : addr_q;
        acc_wdata = (state_q == IDLE) ? bus.i_wdata : wdata_q;
        acc_wstrb = (state_q == IDLE) ? bus.i_wstrb : wstrb_q;
        acc_idx   = acc_addr[ADDR_WIDTH-1:0];
        acc_oor   = (acc_addr[31:ADDR_WIDTH] != '0);
        mem_rd    = mem[acc_idx];
        merged    = mem_rd;
        for (int unsigned b = 0; b < 4; b++) begin
            if (acc_wstrb[b]) merged[8*b +: 8] = acc_wdata[8*b +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        access  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    addr_d  = bus.i_addr;
                    wdata_d = bus.i_wdata;
                    wstrb_d = bus.i_wstrb;
                    cnt_d   = CNT_LOAD;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    access  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rdata_d = rdata_q;
        err_d   = err_q;
        if (access) begin
            rdata_d = acc_oor ? ERR_DATA : merged;
            err_d   = acc_oor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Memory is deliberately outside the reset domain; contents survive rst.
    always_ff @(posedge clk) begin
        if (access && !acc_oor && !rst) mem[acc_idx] <= merged;
    end

    assign bus.o_ready = (state_q == RESP);
    assign bus.o_rdata = rdata_q;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_sys_mem_resp.sv
// Directed bench for sys_mem_resp: vector table on a LATENCY=2 instance,
// hand sequences for streaming (LATENCY=3) and reset corner cases (LATENCY=4).
module tb_sys_mem_resp;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sys_mem_resp_if b2 ();
    sys_mem_resp_if b3 ();
    sys_mem_resp_if b4 ();

    sys_mem_resp #(.ADDR_WIDTH(10), .LATENCY(2), .ERR_DATA(32'hDEAD_BEEF)) u2 (.clk(clk), .rst(rst), .bus(b2));
    sys_mem_resp #(.ADDR_WIDTH(10), .LATENCY(3), .ERR_DATA(32'hDEAD_BEEF)) u3 (.clk(clk), .rst(rst), .bus(b3));
    sys_mem_resp #(.ADDR_WIDTH(10), .LATENCY(4), .ERR_DATA(32'hDEAD_BEEF)) u4 (.clk(clk), .rst(rst), .bus(b4));

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    int pass_cnt = 0;
    int total    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic set_req(input int d, input logic v, input logic [31:0] a,
                           input logic [31:0] w, input logic [3:0] s);
        case (d)
            2: begin b2.i_valid = v; b2.i_addr = a; b2.i_wdata = w; b2.i_wstrb = s; end
            3: begin b3.i_valid = v; b3.i_addr = a; b3.i_wdata = w; b3.i_wstrb = s; end
            default: begin b4.i_valid = v; b4.i_addr = a; b4.i_wdata = w; b4.i_wstrb = s; end
        endcase
    endtask

    function automatic resp_t get(input int d);
        resp_t r;
        case (d)
            2: r = '{b2.o_ready, b2.o_rdata, b2.o_err};
            3: r = '{b3.o_ready, b3.o_rdata, b3.o_err};
            default: r = '{b4.o_ready, b4.o_rdata, b4.o_err};
        endcase
        return r;
    endfunction

    // One request; lat counts cycles from accept to o_ready (-1 on timeout),
    // held reports o_ready dropped while rdata/err stayed put one cycle later.
    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] w,
                       input logic [3:0] s, output logic [31:0] rd, output logic er,
                       output int lat, output logic held);
        resp_t r;
        @(negedge clk);
        set_req(d, 1'b1, a, w, s);
        lat = 0;
        r = get(d);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            r = get(d);
            if (r.ready) break;
        end
        if (!r.ready) lat = -1;
        rd = r.rdata;
        er = r.err;
        set_req(d, 1'b0, '0, '0, '0);
        @(negedge clk);
        r = get(d);
        held = !r.ready && (r.rdata === rd) && (r.err === er);
    endtask

    vec_t        vecs [12];
    logic [31:0] rd;
    logic        er, held, seen;
    int          lat;
    resp_t       r;

    initial begin
        vecs[0]  = '{32'd5,         32'h1122_3344, 4'hF,    32'h1122_3344, 1'b0};
        vecs[1]  = '{32'd5,         32'h0,         4'h0,    32'h1122_3344, 1'b0};
        vecs[2]  = '{32'd5,         32'hAABB_CCDD, 4'b0101, 32'h11BB_33DD, 1'b0};
        vecs[3]  = '{32'd5,         32'h0,         4'h0,    32'h11BB_33DD, 1'b0};
        vecs[4]  = '{32'd0,         32'h0BAD_F00D, 4'hF,    32'h0BAD_F00D, 1'b0};
        vecs[5]  = '{32'h0000_0400, 32'h1234_5678, 4'hF,    32'hDEAD_BEEF, 1'b1};
        vecs[6]  = '{32'd0,         32'h0,         4'h0,    32'h0BAD_F00D, 1'b0};
        vecs[7]  = '{32'h0000_03FF, 32'h5555_AAAA, 4'hF,    32'h5555_AAAA, 1'b0};
        vecs[8]  = '{32'h0000_03FF, 32'h0,         4'h0,    32'h5555_AAAA, 1'b0};
        vecs[9]  = '{32'h8000_0000, 32'h0,         4'h0,    32'hDEAD_BEEF, 1'b1};
        vecs[10] = '{32'h0000_03FF, 32'hFF00_0000, 4'b1000, 32'hFF55_AAAA, 1'b0};
        vecs[11] = '{32'd0,         32'h0,         4'h0,    32'h0BAD_F00D, 1'b0};

        set_req(2, 1'b0, '0, '0, '0);
        set_req(3, 1'b0, '0, '0, '0);
        set_req(4, 1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        for (int d = 2; d <= 4; d++) begin
            r = get(d);
            chk($sformatf("reset ready u%0d", d), 32'(r.ready), 32'd0);
            chk($sformatf("reset err u%0d", d),   32'(r.err),   32'd0);
            chk($sformatf("reset rdata u%0d", d), r.rdata,      32'd0);
        end
        rst = 1'b0;

        // First read after reset: memory content undefined, only timing checked.
        txn(2, 32'd0, 32'd0, 4'h0, rd, er, lat, held);
        chk("first read latency", 32'(lat), 32'd2);
        chk("first read ready pulse", 32'(held), 32'd1);

        for (int i = 0; i < 12; i++) begin
            txn(2, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, er, lat, held);
            chk($sformatf("vec%0d rdata", i),   rd,          vecs[i].exp_rdata);
            chk($sformatf("vec%0d err", i),     32'(er),     32'(vecs[i].exp_err));
            chk($sformatf("vec%0d latency", i), 32'(lat),    32'd2);
            chk($sformatf("vec%0d hold", i),    32'(held),   32'd1);
        end

        // Streaming reads on LATENCY=3: pulses every 4 cycles, address advancing.
        for (int i = 0; i < 4; i++) begin
            txn(3, 32'(i), 32'h3000_0000 + 32'(i), 4'hF, rd, er, lat, held);
            chk($sformatf("stream preload%0d latency", i), 32'(lat), 32'd3);
        end
        begin
            int pulses = 0;
            int last = 0;
            logic [31:0] sa = '0;
            @(negedge clk);
            set_req(3, 1'b1, sa, '0, 4'h0);
            for (int cyc = 0; cyc < 100 && pulses < 4; cyc++) begin
                @(negedge clk);
                r = get(3);
                if (r.ready) begin
                    chk($sformatf("stream rdata%0d", pulses), r.rdata, 32'h3000_0000 + sa);
                    if (pulses > 0) chk($sformatf("stream gap%0d", pulses), 32'(cyc - last), 32'd4);
                    last = cyc;
                    pulses++;
                    sa = sa + 32'd1;
                    set_req(3, 1'b1, sa, '0, 4'h0);
                end
            end
            set_req(3, 1'b0, '0, '0, '0);
            chk("stream pulse count", 32'(pulses), 32'd4);
        end

        // Reset during WAIT on LATENCY=4 aborts the write.
        txn(4, 32'd7, 32'h0, 4'hF, rd, er, lat, held);
        chk("addr7 clear latency", 32'(lat), 32'd4);
        @(negedge clk);
        set_req(4, 1'b1, 32'd7, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        set_req(4, 1'b0, '0, '0, '0);
        seen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (get(4).ready) seen = 1'b1;
        end
        chk("abort no ready", 32'(seen), 32'd0);
        txn(4, 32'd7, 32'h0, 4'h0, rd, er, lat, held);
        chk("abort addr7 rdata", rd, 32'h0);
        chk("abort read latency", 32'(lat), 32'd4);

        // Reset during RESP clears outputs at once; the write already landed.
        @(negedge clk);
        set_req(2, 1'b1, 32'd9, 32'h9999_0000, 4'hF);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (get(2).ready) seen = 1'b1;
        end
        chk("resp-reset reached RESP", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        r = get(2);
        chk("resp-reset ready", 32'(r.ready), 32'd0);
        chk("resp-reset rdata", r.rdata,      32'd0);
        set_req(2, 1'b0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        txn(2, 32'd9, 32'h0, 4'h0, rd, er, lat, held);
        chk("resp-reset write kept", rd, 32'h9999_0000);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
